// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: tag layout, slot states and FU type codes.
// Imported by the reservation stations, Regs and the CDB arbiter.
package tomasulo_pkg;
  localparam int TAG_W  = 8;
  localparam int TYPE_W = 3;
  localparam int IDX_W  = 5;

  typedef logic [TAG_W-1:0] tag_t;

  localparam tag_t TAG_NONE = '0;

  typedef enum logic [1:0] {
    S_FREE,
    S_WAIT,
    S_READY,
    S_EXEC
  } slot_st_e;

  typedef enum logic [TYPE_W-1:0] {
    FU_NONE = 3'd0,
    FU_ALU  = 3'd1,
    FU_MUL  = 3'd2,
    FU_LSU  = 3'd3
  } fu_type_e;

  // Slot i carries index i+1 so that tag 0 stays reserved for "no producer".
  function automatic tag_t slot_tag(
    logic [TYPE_W-1:0] ty,
    int                idx
  );
    return {ty, IDX_W'(idx + 1)};
  endfunction
endpackage

// File: rtl/rs_station_if.sv
// Issue, CDB and FU-dispatch bundle of a reservation station.
// slave = the station, master = the surrounding core.
interface rs_station_if #(
  parameter int ENTRIES = 4,
  parameter int OP_W    = 4
);
  import tomasulo_pkg::*;

  logic              issue_valid;
  logic              issue_ready;
  tag_t              issue_tag;
  logic [OP_W-1:0]   issue_op;
  tag_t              issue_qj;
  tag_t              issue_qk;
  logic [31:0]       issue_vj;
  logic [31:0]       issue_vk;
  tag_t              cdb_rs_num;
  logic [31:0]       cdb_data;
  logic              fu_valid;
  logic              fu_ready;
  logic [OP_W-1:0]   fu_op;
  logic [31:0]       fu_a;
  logic [31:0]       fu_b;
  tag_t              fu_tag;
  logic [ENTRIES-1:0] busy;

  modport master (
    output issue_valid, issue_op,
    output issue_qj, issue_qk,
    output issue_vj, issue_vk,
    output cdb_rs_num, cdb_data,
    output fu_ready,
    input  issue_ready, issue_tag,
    input  fu_valid, fu_op,
    input  fu_a, fu_b, fu_tag,
    input  busy
  );

  modport slave (
    input  issue_valid, issue_op,
    input  issue_qj, issue_qk,
    input  issue_vj, issue_vk,
    input  cdb_rs_num, cdb_data,
    input  fu_ready,
    output issue_ready, issue_tag,
    output fu_valid, fu_op,
    output fu_a, fu_b, fu_tag,
    output busy
  );
endinterface

// File: rtl/rs_entry.sv
// One reservation-station slot: state register, operand capture
// and CDB snoop for its pending producer tags.
module rs_entry
  import tomasulo_pkg::*;
#(
  parameter int   OP_W = 4,
  parameter tag_t TAG  = 8'h21
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc,
  input  logic [OP_W-1:0] a_op,
  input  tag_t            a_qj,
  input  tag_t            a_qk,
  input  logic [31:0]     a_vj,
  input  logic [31:0]     a_vk,
  input  tag_t            cdb_tag,
  input  logic [31:0]     cdb_data,
  input  logic            dispatch,
  output slot_st_e        st,
  output logic [OP_W-1:0] op,
  output logic [31:0]     vj,
  output logic [31:0]     vk
);
  tag_t qj;
  tag_t qk;
  logic aj_hit;
  logic ak_hit;
  logic aj_ok;
  logic ak_ok;
  logic sj_hit;
  logic sk_hit;

  always_comb begin
    aj_hit = (cdb_tag != TAG_NONE) && (a_qj == cdb_tag);
    ak_hit = (cdb_tag != TAG_NONE) && (a_qk == cdb_tag);
    aj_ok  = (a_qj == TAG_NONE) || aj_hit;
    ak_ok  = (a_qk == TAG_NONE) || ak_hit;
    sj_hit = (qj != TAG_NONE) && (qj == cdb_tag);
    sk_hit = (qk != TAG_NONE) && (qk == cdb_tag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_FREE;
      op <= '0;
      vj <= '0;
      vk <= '0;
      qj <= TAG_NONE;
      qk <= TAG_NONE;
    end else begin
      unique case (st)
        S_FREE: if (alloc) begin
          op <= a_op;
          vj <= aj_hit ? cdb_data : a_vj;
          vk <= ak_hit ? cdb_data : a_vk;
          qj <= aj_ok ? TAG_NONE : a_qj;
          qk <= ak_ok ? TAG_NONE : a_qk;
          st <= (aj_ok && ak_ok) ? S_READY : S_WAIT;
        end
        S_WAIT: begin
          if (sj_hit) begin
            vj <= cdb_data;
            qj <= TAG_NONE;
          end
          if (sk_hit) begin
            vk <= cdb_data;
            qk <= TAG_NONE;
          end
          if ((qj == TAG_NONE || sj_hit) &&
              (qk == TAG_NONE || sk_hit))
            st <= S_READY;
        end
        S_READY: if (dispatch) st <= S_EXEC;
        S_EXEC: if (cdb_tag == TAG) st <= S_FREE;
      endcase
    end
  end
endmodule

// File: rtl/rs_station.sv
// Tomasulo reservation station: slot array plus lowest-index
// free-slot and ready-slot priority encoders.
module rs_station
  import tomasulo_pkg::*;
#(
  parameter logic [2:0] FU_TYPE = 3'd1,
  parameter int         ENTRIES = 4,
  parameter int         OP_W    = 4
) (
  input  logic          clk,
  input  logic          rst,
  rs_station_if.slave   io
);
  slot_st_e           st   [ENTRIES];
  logic [OP_W-1:0]    e_op [ENTRIES];
  logic [31:0]        e_vj [ENTRIES];
  logic [31:0]        e_vk [ENTRIES];
  logic [ENTRIES-1:0] alloc;
  logic [ENTRIES-1:0] disp;
  logic [ENTRIES-1:0] busy_v;
  logic [4:0]         free_idx;
  logic [4:0]         rdy_idx;
  logic               any_free;
  logic               any_rdy;

  // Descending scan leaves the lowest matching index.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    any_rdy  = 1'b0;
    rdy_idx  = '0;
    busy_v   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      busy_v[i] = (st[i] != S_FREE);
      if (st[i] == S_FREE) begin
        any_free = 1'b1;
        free_idx = 5'(i);
      end
      if (st[i] == S_READY) begin
        any_rdy = 1'b1;
        rdy_idx = 5'(i);
      end
    end
  end

  always_comb begin
    alloc     = '0;
    disp      = '0;
    io.fu_op  = '0;
    io.fu_a   = '0;
    io.fu_b   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      alloc[i] = io.issue_valid && any_free &&
                 (free_idx == 5'(i));
      if (any_rdy && rdy_idx == 5'(i)) begin
        disp[i]  = io.fu_ready;
        io.fu_op = e_op[i];
        io.fu_a  = e_vj[i];
        io.fu_b  = e_vk[i];
      end
    end
  end

  assign io.issue_ready = any_free;
  assign io.issue_tag   = any_free ?
    slot_tag(FU_TYPE, int'(free_idx)) : TAG_NONE;
  assign io.fu_valid    = any_rdy;
  assign io.fu_tag      = any_rdy ?
    slot_tag(FU_TYPE, int'(rdy_idx)) : TAG_NONE;
  assign io.busy        = busy_v;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_slot
    rs_entry #(
      .OP_W (OP_W),
      .TAG  (slot_tag(FU_TYPE, g))
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .alloc    (alloc[g]),
      .a_op     (io.issue_op),
      .a_qj     (io.issue_qj),
      .a_qk     (io.issue_qk),
      .a_vj     (io.issue_vj),
      .a_vk     (io.issue_vk),
      .cdb_tag  (io.cdb_rs_num),
      .cdb_data (io.cdb_data),
      .dispatch (disp[g]),
      .st       (st[g]),
      .op       (e_op[g]),
      .vj       (e_vj[g]),
      .vk       (e_vk[g])
    );
  end
endmodule

// File: tb/tb_rs_station.sv
// Randomised scoreboard bench for rs_station against a slot-list
// model of allocation, CDB wake-up, dispatch and release.
module tb_rs_station;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_station_if #(.ENTRIES(N), .OP_W(4)) io ();

  rs_station #(
    .FU_TYPE (3'd1),
    .ENTRIES (N),
    .OP_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    bit          iv;
    logic [3:0]  op;
    logic [7:0]  qj;
    logic [31:0] vj;
    logic [7:0]  qk;
    logic [31:0] vk;
    logic [7:0]  ct;
    logic [31:0] cd;
    bit          fr;
    bit          r;
  } in_t;

  typedef struct {
    bit          used;
    bit          sent;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  qa;
    logic [7:0]  qb;
  } slot_m;

  typedef struct {
    bit         ir;
    logic [7:0] tag;
    logic [3:0] busy;
    bit         fv;
  } stat_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  tag;
  } disp_t;

  slot_m m [N];
  in_t   cur;
  stat_t stq [$];
  disp_t sbq [$];
  int    checks = 0;
  int    failures = 0;

  function automatic logic [7:0] tag_of(int i);
    return 8'h20 + 8'(i + 1);
  endfunction

  function automatic int first_free();
    for (int i = 0; i < N; i++) if (!m[i].used) return i;
    return -1;
  endfunction

  function automatic int first_ready();
    for (int i = 0; i < N; i++)
      if (m[i].used && !m[i].sent && m[i].qa == 0 && m[i].qb == 0)
        return i;
    return -1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input in_t x);
    slot_m nm [N];
    int fi;
    int ri;
    if (x.r) begin
      for (int i = 0; i < N; i++) begin
        m[i].used = 0;
        m[i].sent = 0;
      end
      return;
    end
    fi = first_free();
    ri = first_ready();
    nm = m;
    for (int i = 0; i < N; i++) begin
      if (m[i].used && !m[i].sent) begin
        if (m[i].qa != 0 && m[i].qa == x.ct) begin
          nm[i].a = x.cd; nm[i].qa = 0;
        end
        if (m[i].qb != 0 && m[i].qb == x.ct) begin
          nm[i].b = x.cd; nm[i].qb = 0;
        end
      end
      if (m[i].used && m[i].sent && tag_of(i) == x.ct) begin
        nm[i].used = 0; nm[i].sent = 0;
      end
    end
    if (ri >= 0 && x.fr) nm[ri].sent = 1;
    if (x.iv && fi >= 0) begin
      nm[fi].used = 1;
      nm[fi].sent = 0;
      nm[fi].op = x.op;
      if (x.qj == 0) begin nm[fi].a = x.vj; nm[fi].qa = 0; end
      else if (x.qj == x.ct) begin nm[fi].a = x.cd; nm[fi].qa = 0; end
      else begin nm[fi].a = 0; nm[fi].qa = x.qj; end
      if (x.qk == 0) begin nm[fi].b = x.vk; nm[fi].qb = 0; end
      else if (x.qk == x.ct) begin nm[fi].b = x.cd; nm[fi].qb = 0; end
      else begin nm[fi].b = 0; nm[fi].qb = x.qk; end
    end
    m = nm;
  endtask

  task automatic step(input in_t x);
    stat_t s;
    disp_t d;
    int fi;
    int ri;
    @(posedge clk);
    #1;
    model_update(cur);
    cur = x;
    rst            = x.r;
    io.issue_valid = x.iv;
    io.issue_op    = x.op;
    io.issue_qj    = x.qj;
    io.issue_vj    = x.vj;
    io.issue_qk    = x.qk;
    io.issue_vk    = x.vk;
    io.cdb_rs_num  = x.ct;
    io.cdb_data    = x.cd;
    io.fu_ready    = x.fr;
    fi = first_free();
    ri = first_ready();
    s.ir = (fi >= 0);
    s.tag = (fi >= 0) ? tag_of(fi) : 8'h00;
    s.fv = (ri >= 0);
    for (int i = 0; i < N; i++) s.busy[i] = m[i].used;
    stq.push_back(s);
    if (ri >= 0 && x.fr) begin
      d.op = m[ri].op; d.a = m[ri].a; d.b = m[ri].b; d.tag = tag_of(ri);
      sbq.push_back(d);
    end
  endtask

  function automatic in_t mk(bit iv, logic [3:0] op,
    logic [7:0] qj, logic [31:0] vj, logic [7:0] qk, logic [31:0] vk,
    logic [7:0] ct, logic [31:0] cd, bit fr, bit r);
    in_t x;
    x.iv = iv; x.op = op; x.qj = qj; x.vj = vj; x.qk = qk; x.vk = vk;
    x.ct = ct; x.cd = cd; x.fr = fr; x.r = r;
    return x;
  endfunction

  function automatic in_t idle(logic [7:0] ct, logic [31:0] cd, bit fr);
    return mk(0, 0, 0, 0, 0, 0, ct, cd, fr, 0);
  endfunction

  function automatic logic [7:0] rnd_q();
    if ($urandom_range(1, 0) == 0) return 8'h00;
    return 8'h40 + 8'($urandom_range(4, 1));
  endfunction

  function automatic in_t rnd_in(int piv, int pfr);
    in_t x;
    int  ex [$];
    int  c;
    x = mk($urandom_range(99, 0) < piv, 4'($urandom), rnd_q(), $urandom,
           rnd_q(), $urandom, 8'h00, $urandom, $urandom_range(99, 0) < pfr,
           $urandom_range(299, 0) == 0);
    for (int i = 0; i < N; i++) if (m[i].used && m[i].sent) ex.push_back(i);
    c = $urandom_range(9, 0);
    if (c < 4 && ex.size() > 0)
      x.ct = tag_of(ex[$urandom_range(ex.size() - 1, 0)]);
    else if (c < 7)
      x.ct = 8'h40 + 8'($urandom_range(4, 1));
    return x;
  endfunction

  always @(negedge clk) begin
    stat_t s;
    disp_t d;
    if (stq.size() > 0) begin
      s = stq.pop_front();
      chk("issue_ready", 32'(io.issue_ready), 32'(s.ir));
      if (s.ir) chk("issue_tag", 32'(io.issue_tag), 32'(s.tag));
      chk("busy", 32'(io.busy), 32'(s.busy));
      chk("fu_valid", 32'(io.fu_valid), 32'(s.fv));
      if (!io.fu_valid)
        chk("fu_idle_zero", io.fu_a | io.fu_b | 32'(io.fu_op) |
            32'(io.fu_tag), 32'h0);
      if (io.fu_valid && io.fu_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_dispatch", 32'(io.fu_tag), 32'h0);
        end else begin
          d = sbq.pop_front();
          chk("fu_tag", 32'(io.fu_tag), 32'(d.tag));
          chk("fu_op", 32'(io.fu_op), 32'(d.op));
          chk("fu_a", io.fu_a, d.a);
          chk("fu_b", io.fu_b, d.b);
        end
      end
    end
  end

  initial begin
    int piv;
    int pfr;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    io.issue_valid = 0; io.issue_op = 0;
    io.issue_qj = 0; io.issue_vj = 0;
    io.issue_qk = 0; io.issue_vk = 0;
    io.cdb_rs_num = 0; io.cdb_data = 0;
    io.fu_ready = 0;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(idle(8'h00, 0, 0));
    // minimum-latency issue and dispatch
    step(mk(1, 3, 8'h00, 5, 8'h00, 7, 8'h00, 0, 1, 0));
    step(idle(8'h00, 0, 1));
    step(idle(8'h21, 32'h99, 0));
    // pending j woken by CDB two cycles later
    step(mk(1, 5, 8'h45, 0, 8'h00, 9, 8'h00, 0, 1, 0));
    step(idle(8'h00, 0, 1));
    step(idle(8'h45, 32'hDEAD, 1));
    step(idle(8'h00, 0, 1));
    step(idle(8'h21, 0, 1));
    // k captured from CDB in the issue cycle
    step(mk(1, 6, 8'h00, 4, 8'h45, 0, 8'h45, 32'h1234, 0, 0));
    step(idle(8'h00, 0, 1));
    // fill all slots, then a fifth issue is ignored
    for (int i = 0; i < 6; i++)
      step(mk(1, 4'(i), 8'h00, 32'(i), 8'h00, 32'(i + 100), 8'h00, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(idle(8'h00, 0, 0));
    step(idle(8'h00, 0, 1));
    step(idle(8'h00, 0, 1));
    step(idle(8'h23, 0, 0));
    step(mk(1, 9, 8'h00, 1, 8'h00, 2, 8'h00, 0, 0, 0));
    // reset with slots in flight
    step(mk(1, 2, 8'h47, 0, 8'h00, 3, 8'h00, 0, 0, 1));
    step(idle(8'h00, 0, 0));
    for (int k = 0; k < 3000; k++) begin
      piv = ((k / 300) % 3 == 0) ? 90 : 50;
      pfr = ((k / 300) % 2 == 0) ? 30 : 80;
      step(rnd_in(piv, pfr));
    end
    for (int i = 0; i < 4; i++) step(idle(8'h00, 0, 0));
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
